// File: rtl/model_test_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : model_test_mul_arb
// Brief    : Round-robin share of one 12s x 8s -> 19-bit multiplier among NREQ
//            requesters, with a registered tagged output stage.
//            Optional burst lock compiled in with MUL_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module model_test_mul_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*12-1:0]  req_a,
  input  logic [NREQ*8-1:0]   req_b,
  input  logic [NREQ-1:0]     req_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [18:0]         out_data,
  output logic [IDW-1:0]      out_id,
  output logic                busy
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [18:0]        out_data_q, out_data_d;
  logic [IDW-1:0]     out_id_q, out_id_d;

  logic               w_adv;
  logic               w_gnt_vld;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_xfer;
  logic signed [11:0] w_a;
  logic signed [7:0]  w_b;
  logic [18:0]        w_prod;

`ifdef MUL_ARB_LOCK_EN
  logic               lock_q, lock_d;
  logic [IDW-1:0]     lock_id_q, lock_id_d;
`else
  logic               w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin : p_grant
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_vld && req_valid[wrap_add(ptr_q, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = wrap_add(ptr_q, k);
      end
    end
`ifdef MUL_ARB_LOCK_EN
    // A locked burst owns the multiplier; a gap from its owner is a bubble.
    if (lock_q) begin
      w_gnt_vld = req_valid[lock_id_q];
      w_gnt_idx = lock_id_q;
    end
`endif
  end

  assign w_adv  = !out_valid_q || out_ready;
  assign w_xfer = w_gnt_vld && w_adv && !ap_rst;

  always_comb begin : p_ready
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_a = req_a[int'(w_gnt_idx)*12 +: 12];
  assign w_b = req_b[int'(w_gnt_idx)*8 +: 8];
  // Low 19 bits of a modular product equal those of the full 20-bit product.
  assign w_prod = 19'(w_a) * 19'(w_b);

  always_comb begin : p_next
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_prod;
      out_id_d    = w_gnt_idx;
      ptr_d       = wrap_add(w_gnt_idx, 1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef MUL_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (w_xfer) begin
      if (req_last[w_gnt_idx]) begin
        lock_d = 1'b0;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = w_gnt_idx;
        ptr_d     = ptr_q;
      end
    end
`endif
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin : p_regs
    if (ap_rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
`ifdef MUL_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
`ifdef MUL_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = out_valid_q || (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_model_test_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_model_test_mul_arb
// Brief    : Directed-vector bench for model_test_mul_arb (NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_model_test_mul_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [47:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_last;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_data;
  logic [1:0]  out_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  model_test_mul_arb #(.NREQ(4), .IDW(2)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [3:0]        valid;
    logic [3:0][11:0]  a;
    logic [3:0][7:0]   b;
    logic              ordy;
    logic [3:0]        ready;
    logic              ov;
    logic [18:0]       data;
    logic [1:0]        id;
  } vec_t;

  localparam int NV = 17;
  localparam logic [47:0] A_RR = {12'd40, 12'd30, 12'd20, 12'd10};
  localparam logic [31:0] B_RR = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [47:0] A_S2 = {12'd0, 12'd100, 12'd0, 12'd0};
  localparam logic [31:0] B_S2 = {8'd0, 8'hFD, 8'd0, 8'd0};
  localparam logic [47:0] A_X1 = {12'd0, 12'h800, 12'd0, 12'd0};
  localparam logic [31:0] B_X1 = {8'd0, 8'h80, 8'd0, 8'd0};
  localparam logic [47:0] A_X2 = {36'd0, 12'h7FF};
  localparam logic [31:0] B_X2 = {24'd0, 8'h80};

  vec_t tbl [NV];
  int   exp_ids [5];

  function automatic vec_t mk(input logic [3:0] v, input logic [47:0] a, input logic [31:0] b,
                              input logic r, input logic [3:0] er, input logic ov,
                              input int d, input int id);
    vec_t t;
    t.valid = v;  t.a = a;  t.b = b;  t.ordy = r;
    t.ready = er; t.ov = ov; t.data = d[18:0]; t.id = id[1:0];
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_last  = 4'b0000;
    out_ready = 1'b1;

    // Starting from ptr=0 after reset.
    tbl[0]  = mk(4'b0100, A_S2, B_S2, 1'b1, 4'b0100, 1'b1, -300, 2);
    tbl[1]  = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 160, 3);
    tbl[2]  = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b0001, 1'b1, 10, 0);
    tbl[3]  = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b0010, 1'b1, 40, 1);
    tbl[4]  = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b0100, 1'b1, 90, 2);
    tbl[5]  = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 160, 3);
    tbl[6]  = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b0001, 1'b1, 10, 0);
    tbl[7]  = mk(4'b1111, A_RR, B_RR, 1'b0, 4'b0000, 1'b1, 10, 0);
    tbl[8]  = mk(4'b1111, A_RR, B_RR, 1'b0, 4'b0000, 1'b1, 10, 0);
    tbl[9]  = mk(4'b1111, A_RR, B_RR, 1'b0, 4'b0000, 1'b1, 10, 0);
    tbl[10] = mk(4'b1111, A_RR, B_RR, 1'b1, 4'b0010, 1'b1, 40, 1);
    tbl[11] = mk(4'b0100, A_X1, B_X1, 1'b1, 4'b0100, 1'b1, 'h40000, 2);
    tbl[12] = mk(4'b0001, A_X2, B_X2, 1'b1, 4'b0001, 1'b1, -262016, 0);
    tbl[13] = mk(4'b0000, A_RR, B_RR, 1'b1, 4'b0000, 1'b0, 0, 0);
    tbl[14] = mk(4'b0000, A_RR, B_RR, 1'b0, 4'b0000, 1'b0, 0, 0);
    tbl[15] = mk(4'b1001, A_RR, B_RR, 1'b1, 4'b1000, 1'b1, 160, 3);
    tbl[16] = mk(4'b1001, A_RR, B_RR, 1'b1, 4'b0001, 1'b1, 10, 0);

`ifdef MUL_ARB_LOCK_EN
    exp_ids = '{1, 1, 1, 3, 0};
`else
    exp_ids = '{1, 3, 0, 1, 3};
`endif

    #3;
    chk("rst_ov",    int'(out_valid), 0);
    chk("rst_data",  int'(out_data),  0);
    chk("rst_id",    int'(out_id),    0);
    chk("rst_ready", int'(req_ready), 0);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    req_valid = 4'b0000;
    @(posedge ap_clk); #1;

    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].valid;
      req_a     = tbl[i].a;
      req_b     = tbl[i].b;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), int'(req_ready), int'(tbl[i].ready));
      @(posedge ap_clk); #1;
      chk($sformatf("v%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("v%0d_data", i), int'(out_data), int'(tbl[i].data));
        chk($sformatf("v%0d_id", i),   int'(out_id),   int'(tbl[i].id));
      end
    end

    // Mid-stream reset with a held product; ptr is 3 before reset.
    req_valid = 4'b0100;
    req_a     = A_RR;
    req_b     = B_RR;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("pre_rst_id", int'(out_id), 2);
    req_valid = 4'b1100;
    out_ready = 1'b0;
    #2 ap_rst = 1'b1;
    #1;
    chk("mid_rst_ov",    int'(out_valid), 0);
    chk("mid_rst_data",  int'(out_data),  0);
    chk("mid_rst_id",    int'(out_id),    0);
    chk("mid_rst_ready", int'(req_ready), 0);
    @(negedge ap_clk);
    ap_rst    = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", int'(req_ready), 4'b0100);
    @(posedge ap_clk); #1;
    chk("post_rst_ov",   int'(out_valid), 1);
    chk("post_rst_id",   int'(out_id),    2);
    chk("post_rst_data", int'(out_data),  90);

    // Move ptr to 1, then run the burst scenario.
    req_valid = 4'b0001;
    @(posedge ap_clk); #1;
    chk("burst_pre_id", int'(out_id), 0);
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b1011;
      req_last  = {1'b1, 1'b0, (c >= 2), 1'b1};
      #1;
      chk($sformatf("burst%0d_ready", c), int'(req_ready), 1 << exp_ids[c]);
      @(posedge ap_clk); #1;
      chk($sformatf("burst%0d_id", c), int'(out_id), exp_ids[c]);
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    @(posedge ap_clk); #1;
    chk("drain_ov",   int'(out_valid), 0);
    chk("drain_busy", int'(busy),      0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
